// File: rtl/pc_fetch.sv
// Instruction-fetch sequencer: owns the fetch PC, reads imem with a held req/rdy
// handshake and offers one buffered word to decode. Optional FETCH_CNT_EN adds fetch_cnt.
module pc_fetch #(
    parameter int              N      = 9,
    parameter int              W      = 32,
    parameter logic [N-1:0]    RST_PC = {N{1'b1}}
) (
    input  logic          btn,
    input  logic          rst,
    output logic          imem_req,
    output logic [N-1:0]  imem_addr,
    input  logic          imem_rdy,
    input  logic [W-1:0]  imem_data,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [W-1:0]  inst_out,
    output logic [N-1:0]  inst_pc,
    input  logic          redir,
    input  logic [N-1:0]  redir_pc,
    output logic [N-1:0]  o_pc
`ifdef FETCH_CNT_EN
    ,
    output logic [15:0]   fetch_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        VALID = 2'b10
    } state_t;

    localparam logic [N-1:0] PC_ONE = {{(N-1){1'b0}}, 1'b1};

    state_t         state_r;
    logic [N-1:0]   pc_r;
    logic [W-1:0]   inst_r;
    logic [N-1:0]   inst_pc_r;
    logic           req_r;
    logic           valid_r;

    // Fetch FSM; req/valid are registered alongside the state they decode.
    always_ff @(posedge btn or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            pc_r      <= RST_PC;
            inst_r    <= {W{1'b0}};
            inst_pc_r <= {N{1'b0}};
            req_r     <= 1'b0;
            valid_r   <= 1'b0;
        end else if (redir) begin
            // Redirect wins everywhere: drops any buffered word and abandons a pending read.
            state_r   <= FETCH;
            pc_r      <= redir_pc;
            req_r     <= 1'b1;
            valid_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= FETCH;
                    pc_r    <= pc_r + PC_ONE;
                    req_r   <= 1'b1;
                    valid_r <= 1'b0;
                end
                FETCH: begin
                    if (imem_rdy) begin
                        state_r   <= VALID;
                        inst_r    <= imem_data;
                        inst_pc_r <= pc_r;
                        req_r     <= 1'b0;
                        valid_r   <= 1'b1;
                    end else begin
                        state_r <= FETCH;
                        req_r   <= 1'b1;
                        valid_r <= 1'b0;
                    end
                end
                VALID: begin
                    if (inst_ready) begin
                        state_r <= FETCH;
                        pc_r    <= pc_r + PC_ONE;
                        req_r   <= 1'b1;
                        valid_r <= 1'b0;
                    end else begin
                        state_r <= VALID;
                        req_r   <= 1'b0;
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = req_r;
    assign imem_addr  = pc_r;
    assign o_pc       = pc_r;
    assign inst_valid = valid_r;
    assign inst_out   = inst_r;
    assign inst_pc    = inst_pc_r;

`ifdef FETCH_CNT_EN
    logic [15:0] cnt_r;

    // Counts decoder handshakes not overridden by a same-cycle redirect; saturates.
    always_ff @(posedge btn or negedge rst) begin
        if (!rst) begin
            cnt_r <= 16'h0000;
        end else if ((state_r == VALID) && inst_ready && !redir && (cnt_r != 16'hFFFF)) begin
            cnt_r <= cnt_r + 16'h0001;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign fetch_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_pc_fetch;

    logic        btn = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic        imem_rdy = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [8:0]  inst_pc;
    logic        redir = 1'b0;
    logic [8:0]  redir_pc = 9'h0;
    logic [8:0]  o_pc;
`ifdef FETCH_CNT_EN
    logic [15:0] fetch_cnt;
`endif

    pc_fetch dut (
        .btn(btn), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_data(imem_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_out(inst_out), .inst_pc(inst_pc),
        .redir(redir), .redir_pc(redir_pc), .o_pc(o_pc)
`ifdef FETCH_CNT_EN
        , .fetch_cnt(fetch_cnt)
`endif
    );

    always #5 btn = ~btn;

    int checks = 0;
    int errors = 0;

    // Reference model: has the sequencer started, is a word buffered, and what it holds.
    bit          m_started;
    bit          m_has;
    int          m_pc;
    int          m_ipc;
    logic [31:0] m_inst;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_has     = 1'b0;
        m_pc      = 511;
        m_ipc     = 0;
        m_inst    = 32'h0;
        m_cnt     = 0;
    endtask

    task automatic model_edge();
        if (m_has && inst_ready && !redir)
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        if (!m_started) begin
            m_pc      = redir ? int'(redir_pc) : (m_pc + 1) % 512;
            m_started = 1'b1;
            m_has     = 1'b0;
        end else if (redir) begin
            m_pc  = int'(redir_pc);
            m_has = 1'b0;
        end else if (!m_has) begin
            if (imem_rdy) begin
                m_has  = 1'b1;
                m_inst = imem_data;
                m_ipc  = m_pc;
            end
        end else if (inst_ready) begin
            m_pc  = (m_pc + 1) % 512;
            m_has = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("o_pc",       32'(o_pc),       32'(m_pc));
        chk("imem_addr",  32'(imem_addr),  32'(m_pc));
        chk("imem_req",   32'(imem_req),   32'(m_started && !m_has));
        chk("inst_valid", 32'(inst_valid), 32'(m_has));
        chk("inst_out",   inst_out,        m_inst);
        chk("inst_pc",    32'(inst_pc),    32'(m_ipc));
`ifdef FETCH_CNT_EN
        chk("fetch_cnt",  32'(fetch_cnt),  32'(m_cnt));
`endif
    endtask

    task automatic step();
        @(posedge btn);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic [8:0] exp_seq [6];
        logic [8:0] hold_addr;
        bit         reached;

        model_reset();
        repeat (2) @(posedge btn);
        #1;
        check_all();

        // Streaming with imem and decoder always ready.
        imem_rdy   = 1'b1;
        inst_ready = 1'b1;
        imem_data  = $urandom;
        rst        = 1'b1;
        chk("pc_seq_init", 32'(o_pc), 32'h1FF);
        exp_seq = '{9'h000, 9'h000, 9'h001, 9'h001, 9'h002, 9'h002};
        for (int i = 0; i < 6; i++) begin
            step();
            imem_data = $urandom;
            chk("pc_seq", 32'(o_pc), 32'(exp_seq[i]));
            if (i % 2 == 1)
                chk("inst_pc_seq", 32'(inst_pc), 32'(i / 2));
        end

        // Reach FETCH, then stall imem for 5 cycles.
        reached = 1'b0;
        imem_rdy = 1'b0;
        for (int i = 0; i < 10 && !reached; i++) begin
            step();
            reached = m_started && !m_has;
        end
        chk("reach_fetch", 32'(reached), 32'h1);
        hold_addr = imem_addr;
        for (int i = 0; i < 5; i++) begin
            imem_data = $urandom;
            step();
            chk("stall_addr", 32'(imem_addr), 32'(hold_addr));
        end
        imem_rdy   = 1'b1;
        imem_data  = 32'hDEADBEEF;
        inst_ready = 1'b0;
        step();
        chk("deadbeef", inst_out, 32'hDEADBEEF);

        // Decoder back-pressure for 3 cycles.
        imem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_data = $urandom;
            step();
        end

        // Redirect in VALID with inst_ready high: word dropped, not counted.
        redir      = 1'b1;
        redir_pc   = 9'h040;
        inst_ready = 1'b1;
        step();
        chk("redir_pc", 32'(o_pc), 32'h040);
        chk("redir_drop", 32'(inst_valid), 32'h0);
        redir      = 1'b0;
        inst_ready = 1'b0;
        imem_rdy   = 1'b1;
        imem_data  = $urandom;
        step();
        chk("redir_inst_pc", 32'(inst_pc), 32'h040);

        // Wrap from 1FF to 000.
        redir      = 1'b1;
        redir_pc   = 9'h1FF;
        inst_ready = 1'b1;
        step();
        redir = 1'b0;
        step();
        chk("wrap_inst_pc", 32'(inst_pc), 32'h1FF);
        step();
        chk("wrap_addr", 32'(imem_addr), 32'h000);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            imem_rdy   = 1'($urandom_range(0, 1));
            inst_ready = 1'($urandom_range(0, 1));
            redir      = ($urandom_range(0, 9) == 0);
            redir_pc   = 9'($urandom);
            imem_data  = $urandom;
            step();
        end

        // Async reset while a fetch is pending.
        redir    = 1'b0;
        imem_rdy = 1'b0;
        step();
        step();
        chk("pre_rst_req", 32'(imem_req), 32'h1);
        #3;
        rst = 1'b0;
        #1;
        chk("async_pc", 32'(o_pc), 32'h1FF);
        chk("async_req", 32'(imem_req), 32'h0);
        chk("async_valid", 32'(inst_valid), 32'h0);
        model_reset();
        check_all();
        #2;
        rst = 1'b1;

        // Redirect on the IDLE cycle: target taken with no increment.
        redir    = 1'b1;
        redir_pc = 9'h0AB;
        step();
        chk("idle_redir", 32'(o_pc), 32'h0AB);
        redir = 1'b0;

        for (int i = 0; i < 200; i++) begin
            imem_rdy   = 1'($urandom_range(0, 1));
            inst_ready = 1'($urandom_range(0, 1));
            redir      = ($urandom_range(0, 15) == 0);
            redir_pc   = 9'($urandom);
            imem_data  = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
